// File: rtl/mcp_datapath.sv
`timescale 1ns/1ps
// Multicycle MIPS datapath: PC, IR/MDR/A/B/ALUOut, 32x32 register file and ALU.
// Define MCP_PERF_CNT_EN to add the cycle_count / instr_count performance counters.
module mcp_datapath #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pcen,
  input  logic        irwrite,
  input  logic        regwrite,
  input  logic        alusrca,
  input  logic        iord,
  input  logic        memtoreg,
  input  logic        regdst,
  input  logic [1:0]  alusrcb,
  input  logic [1:0]  pcsrc,
  input  logic [2:0]  alucontrol,
  input  logic [31:0] readdata,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic        zero,
  output logic [31:0] adr,
  output logic [31:0] writedata
`ifdef MCP_PERF_CNT_EN
  ,
  output logic [31:0] cycle_count,
  output logic [31:0] instr_count
`endif
);

  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [31:0] r_mdr;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_aluout;
  logic [31:0] r_rf [32];

  logic [31:0] w_signimm;
  logic [31:0] w_srca;
  logic [31:0] w_srcb;
  logic [31:0] w_alu_result;
  logic        w_slt;
  logic [31:0] w_pcnext;
  logic [4:0]  w_waddr;
  logic [31:0] w_wdata;
  logic [31:0] w_rd1;
  logic [31:0] w_rd2;
  logic        w_unused_shamt;

  // shamt is not used by any supported ALU operation
  assign w_unused_shamt = ^r_ir[10:6];

  assign w_signimm = {{16{r_ir[15]}}, r_ir[15:0]};
  assign w_srca    = alusrca ? r_a : r_pc;
  assign w_slt     = $signed(w_srca) < $signed(w_srcb);
  assign w_waddr   = regdst ? r_ir[15:11] : r_ir[20:16];
  assign w_wdata   = memtoreg ? r_mdr : r_aluout;
  assign w_rd1     = r_rf[r_ir[25:21]];
  assign w_rd2     = r_rf[r_ir[20:16]];

  always_comb begin
    w_srcb = r_b;
    case (alusrcb)
      2'b00:   w_srcb = r_b;
      2'b01:   w_srcb = 32'd4;
      2'b10:   w_srcb = w_signimm;
      default: w_srcb = {w_signimm[29:0], 2'b00};
    endcase
  end

  always_comb begin
    w_alu_result = '0;
    case (alucontrol)
      3'b010:  w_alu_result = w_srca + w_srcb;
      3'b110:  w_alu_result = w_srca - w_srcb;
      3'b000:  w_alu_result = w_srca & w_srcb;
      3'b001:  w_alu_result = w_srca | w_srcb;
      3'b111:  w_alu_result = {31'd0, w_slt};
      default: w_alu_result = '0;
    endcase
  end

  always_comb begin
    w_pcnext = r_pc;
    case (pcsrc)
      2'b00:   w_pcnext = w_alu_result;
      2'b01:   w_pcnext = r_aluout;
      2'b10:   w_pcnext = {r_pc[31:28], r_ir[25:0], 2'b00};
      default: w_pcnext = r_pc;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc     <= RESET_PC;
      r_ir     <= '0;
      r_mdr    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_aluout <= '0;
    end else begin
      if (pcen)    r_pc <= w_pcnext;
      if (irwrite) r_ir <= readdata;
      r_mdr    <= readdata;
      r_a      <= w_rd1;
      r_b      <= w_rd2;
      r_aluout <= w_alu_result;
    end
  end

  // Register 0 is never written, so it keeps its reset value of zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) r_rf[i] <= '0;
    end else if (regwrite && (w_waddr != 5'd0)) begin
      r_rf[w_waddr] <= w_wdata;
    end
  end

`ifdef MCP_PERF_CNT_EN
  logic [31:0] r_cycle_count;
  logic [31:0] r_instr_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cycle_count <= '0;
      r_instr_count <= '0;
    end else begin
      r_cycle_count <= r_cycle_count + 32'd1;
      if (irwrite) r_instr_count <= r_instr_count + 32'd1;
    end
  end

  assign cycle_count = r_cycle_count;
  assign instr_count = r_instr_count;
`endif

  assign op        = r_ir[31:26];
  assign funct     = r_ir[5:0];
  assign zero      = (w_alu_result == 32'd0);
  assign adr       = iord ? r_aluout : r_pc;
  assign writedata = r_b;

endmodule

// File: tb/tb_mcp_datapath.sv
`timescale 1ns/1ps
// Scoreboard bench for mcp_datapath: stimulus queues expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_mcp_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic        pcen, irwrite, regwrite, alusrca, iord, memtoreg, regdst;
  logic [1:0]  alusrcb, pcsrc;
  logic [2:0]  alucontrol;
  logic [31:0] readdata;
  logic [5:0]  op, funct;
  logic        zero;
  logic [31:0] adr, writedata;
`ifdef MCP_PERF_CNT_EN
  logic [31:0] cycle_count, instr_count;
`endif

  localparam int S_ADR = 0, S_OP = 1, S_FUNCT = 2, S_ZERO = 3, S_WDATA = 4,
                 S_CYC = 5, S_INS = 6;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        m_e;
  logic [31:0] m_act;
  int          n_cmp = 0;
  int          n_err = 0;

  mcp_datapath dut (
    .clk(clk), .reset(reset), .pcen(pcen), .irwrite(irwrite), .regwrite(regwrite),
    .alusrca(alusrca), .iord(iord), .memtoreg(memtoreg), .regdst(regdst),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .readdata(readdata),
    .op(op), .funct(funct), .zero(zero), .adr(adr), .writedata(writedata)
`ifdef MCP_PERF_CNT_EN
    , .cycle_count(cycle_count), .instr_count(instr_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      S_ADR:   return adr;
      S_OP:    return {26'd0, op};
      S_FUNCT: return {26'd0, funct};
      S_ZERO:  return {31'd0, zero};
      S_WDATA: return writedata;
`ifdef MCP_PERF_CNT_EN
      S_CYC:   return cycle_count;
      S_INS:   return instr_count;
`endif
      default: return 32'hXXXX_XXXX;
    endcase
  endfunction

  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      m_e   = sb_q.pop_front();
      m_act = actual(m_e.sel);
      n_cmp++;
      if (m_act !== m_e.exp) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", m_e.name, m_act, m_e.exp);
      end
    end
  end

  task automatic chk(input string nm, input int sel, input logic [31:0] exp);
    exp_t e;
    e.name = nm;
    e.sel  = sel;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pcen = 0; irwrite = 0; regwrite = 0; alusrca = 0; iord = 0;
    memtoreg = 0; regdst = 0; alusrcb = 2'b00; pcsrc = 2'b00;
    alucontrol = 3'b010; readdata = '0;
  endtask

  // fetch (PC held), decode, execute (rs + imm), write back to rt
  task automatic addi_seq(input logic [31:0] instr);
    idle(); readdata = instr; irwrite = 1; tick();
    idle(); alusrcb = 2'b11; tick();
    idle(); alusrca = 1; alusrcb = 2'b10; tick();
    idle(); regwrite = 1; tick();
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, %0d expectations pending", sb_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    reset = 0;
    tick(); tick();
    chk("rst_adr", S_ADR, 32'h0);
    chk("rst_op", S_OP, 32'h0);
    chk("rst_funct", S_FUNCT, 32'h0);
    chk("rst_wdata", S_WDATA, 32'h0);
    chk("rst_zero", S_ZERO, 32'h1);
    tick();
    reset = 1;

    // addi $8,$0,5 with PC+4 on fetch
    readdata = 32'h2008_0005; irwrite = 1; pcen = 1; alusrcb = 2'b01;
    chk("f1_adr", S_ADR, 32'h0);
    chk("f1_zero", S_ZERO, 32'h0);
    tick();
    idle(); alusrcb = 2'b11;
    chk("d1_op", S_OP, 32'h08);
    chk("d1_funct", S_FUNCT, 32'h05);
    chk("d1_pc4", S_ADR, 32'h4);
    tick();
    idle(); alusrca = 1; alusrcb = 2'b10;
    chk("e1_zero", S_ZERO, 32'h0);
    tick();
    idle(); regwrite = 1;
    chk("w1_b", S_WDATA, 32'h0);
    tick();
    idle();
    chk("rd_old", S_WDATA, 32'h0);
    tick();
    chk("r8_eq5", S_WDATA, 32'h5);
    tick();

    // register 0 write via MDR is discarded
    idle(); readdata = 32'h2000_0000; irwrite = 1; pcen = 1; alusrcb = 2'b01;
    chk("f2_adr", S_ADR, 32'h4);
    tick();
    idle(); readdata = 32'hDEAD_BEEF;
    chk("f2_pc8", S_ADR, 32'h8);
    tick();
    idle(); regwrite = 1; memtoreg = 1;
    tick();
    idle();
    tick();
    chk("r0_zero", S_WDATA, 32'h0);

    addi_seq(32'h2001_0007);
    addi_seq(32'h2002_0007);

    // beq $1,$2,3 at PC=8
    readdata = 32'h1022_0003; irwrite = 1;
    chk("beq_adr", S_ADR, 32'h8);
    tick();
    idle(); alusrcb = 2'b11;
    chk("beq_dec_zero", S_ZERO, 32'h0);
    tick();
    idle(); alusrca = 1; alucontrol = 3'b110; pcsrc = 2'b01; pcen = 1;
    chk("beq_zero", S_ZERO, 32'h1);
    chk("beq_b", S_WDATA, 32'h7);
    tick();
    idle();
    chk("beq_pc", S_ADR, 32'h14);

    // j 0x10
    readdata = 32'h0800_0010; irwrite = 1;
    tick();
    idle(); pcsrc = 2'b10; pcen = 1;
    tick();
    idle(); pcsrc = 2'b11; pcen = 1; alusrcb = 2'b01;
    chk("j_pc", S_ADR, 32'h40);
    chk("j_op", S_OP, 32'h02);
    tick();
    idle();
    chk("hold_pc", S_ADR, 32'h40);

    addi_seq(32'h2003_FFFF);
    addi_seq(32'h2004_0001);

    // slt $5,$3,$4 : A=-1, B=1
    readdata = 32'h0064_282A; irwrite = 1;
    tick();
    idle(); alusrcb = 2'b11;
    tick();
    idle(); alusrca = 1; alucontrol = 3'b111;
    chk("slt1_zero", S_ZERO, 32'h0);
    chk("slt1_b", S_WDATA, 32'h1);
    chk("slt_funct", S_FUNCT, 32'h2A);
    tick();
    alucontrol = 3'b000;
    chk("and_zero", S_ZERO, 32'h0);
    tick();
    alucontrol = 3'b011;
    chk("undef_zero", S_ZERO, 32'h1);
    tick();
    alucontrol = 3'b010;
    chk("add_wrap_zero", S_ZERO, 32'h1);
    tick();

    // slt $5,$4,$3 : A=1, B=-1
    idle(); readdata = 32'h0083_282A; irwrite = 1;
    tick();
    idle(); alusrcb = 2'b11;
    tick();
    idle(); alusrca = 1; alucontrol = 3'b111;
    chk("slt2_zero", S_ZERO, 32'h1);
    chk("slt2_b", S_WDATA, 32'hFFFF_FFFF);
    tick();
    alucontrol = 3'b001;
    chk("or_zero", S_ZERO, 32'h0);
    tick();

    // asynchronous reset mid-run
    idle();
    reset = 0;
    chk("mrst_adr", S_ADR, 32'h0);
    chk("mrst_op", S_OP, 32'h0);
    chk("mrst_funct", S_FUNCT, 32'h0);
    chk("mrst_wdata", S_WDATA, 32'h0);
    tick(); tick();
    reset = 1;

    for (int c = 0; c < 10; c++) begin
      idle();
      if (c == 0 || c == 4 || c == 8) begin
        readdata = 32'h2008_0000;
        irwrite  = 1;
      end
      tick();
    end
    idle();
`ifdef MCP_PERF_CNT_EN
    chk("cycle_count", S_CYC, 32'd10);
    chk("instr_count", S_INS, 32'd3);
`endif
    chk("post_rst_r8", S_WDATA, 32'h0);
    chk("post_rst_adr", S_ADR, 32'h0);
    chk("post_rst_op", S_OP, 32'h08);
    tick(); tick();
    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mcp_datapath.md
# mcp_datapath

Multicycle MIPS datapath that sits directly downstream of `controller`. It consumes the controller's per-cycle control strobes and returns `op`, `funct` and `zero` to it. It holds the PC, the non-architectural registers (IR, MDR, A, B, ALUOut), the 32×32 register file and the ALU. It drives a unified instruction/data memory port.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.

- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `pcen`  in  1  PC write enable.
- `irwrite`  in  1  instruction register write enable.
- `regwrite`  in  1  register file write enable.
- `alusrca`  in  1  ALU A select: 0 = PC, 1 = A.
- `iord`  in  1  memory address select: 0 = PC, 1 = ALUOut.
- `memtoreg`  in  1  write-back select: 0 = ALUOut, 1 = MDR.
- `regdst`  in  1  destination register select: 0 = rt, 1 = rd.
- `alusrcb`  in  2  ALU B select.
- `pcsrc`  in  2  next-PC select.
- `alucontrol`  in  3  ALU operation.
- `readdata`  in  32  memory read data, valid in the same cycle as `adr` (combinational memory).
- `op`  out  6  IR[31:26].
- `funct`  out  6  IR[5:0].
- `zero`  out  1  ALU result == 0.
- `adr`  out  32  memory address.
- `writedata`  out  32  memory write data; equals B.

## Operation
- **Reset (reset=0, async):** PC=RESET_PC; IR, MDR, A, B, ALUOut and all 32 registers = 0. Consequently `op`=0, `funct`=0, `writedata`=0, and `adr`=RESET_PC when `iord`=0.
- **PC:** loads `pcnext` on edge when `pcen`=1.
  - `pcsrc`=00: ALU result.
  - `pcsrc`=01: ALUOut.
  - `pcsrc`=10: {PC[31:28], IR[25:0], 2'b00}.
  - `pcsrc`=11: PC unchanged, even with `pcen`=1.
- **IR:** loads `readdata` when `irwrite`=1, otherwise holds.
- **Free-running registers:** MDR←`readdata`, A←rf[IR[25:21]], B←rf[IR[20:16]] and ALUOut←ALU result load every cycle.
- **Register file:**
  - Reads are combinational. Register 0 always reads as 0.
  - Write occurs on edge when `regwrite`=1.
  - Write address = `regdst` ? IR[15:11] : IR[20:16].
  - Write data = `memtoreg` ? MDR : ALUOut.
  - Writes to register 0 are discarded.
  - On a same-cycle write and read of one register, A/B capture the old value.
- **ALU operand B:** `alusrcb`=00 B, 01 32'd4, 10 signimm, 11 signimm<<2. signimm = sign-extended IR[15:0].
- **ALU operation** (32-bit, carry/overflow discarded, wraps mod 2^32):
  - 010 add; 110 sub; 000 and; 001 or.
  - 111 slt: signed, result 1 or 0.
  - Other codes: result 0.
- **`zero`:** combinational from the current ALU result.

## Timing
- Combinational paths: `adr`, `op`, `funct`, ALU result and `zero` follow register/input changes within the cycle.
- Fetch: the cycle with `irwrite`=1 and `iord`=0 captures mem[PC]. `op`/`funct` are valid after that edge.
- PC+4 fetch in the same cycle: `alusrca`=0, `alusrcb`=01, `pcsrc`=00, `pcen`=1 → PC+4 visible the next cycle.
- A/B reflect the IR of the previous cycle, i.e. one cycle after IR load (decode state).
- Branch: ALUOut from the decode cycle holds the target. In the next cycle, `pcsrc`=01 with `pcen`=1 loads it.
- Reset asserted mid-instruction clears all state immediately. The first fetch after deassert uses RESET_PC.

## Configuration
- `MCP_PERF_CNT_EN` defined: adds outputs `cycle_count` (out, 32) and `instr_count` (out, 32).
  - `cycle_count` increments on every edge while `reset`=1.
  - `instr_count` increments on every edge with `irwrite`=1.
  - Both reset to 0 and wrap from 32'hFFFF_FFFF to 0.
- Not defined: the ports and counters are absent; all other behaviour is identical.

## Test plan
- **Reset:** `reset`=0 mid-run with `iord`=0 → PC=0, `adr`=0, `op`=0, `funct`=0; rf reads 0 after release.
- **Fetch/decode addi:**
  - Stimulus: `readdata`=32'h2008_0005, `irwrite`=1, PC+4 controls; then `alusrca`=1, `alusrcb`=10, `alucontrol`=010; then `regdst`=0, `memtoreg`=0, `regwrite`=1.
  - Required: `op`=6'b001000, PC=4, then $8=5.
- **Register 0:** write 32'hDEAD_BEEF to register 0 → subsequent read of register 0 gives 0.
- **beq taken:**
  - Stimulus: $1=$2=7, IR=32'h1022_0003 at PC=8; decode with `alusrcb`=11 (ALUOut=8+12=20); then sub with `pcsrc`=01, `pcen`=1.
  - Required: `zero`=1, PC=20.
- **Jump:** IR=32'h0800_0010, `pcsrc`=10, `pcen`=1 → PC=32'h0000_0040. With `pcsrc`=11 → PC unchanged.
- **slt signed:** A=32'hFFFF_FFFF, B=1, `alucontrol`=111 → result 1, `zero`=0. With A=1, B=32'hFFFF_FFFF → result 0, `zero`=1. With `MCP_PERF_CNT_EN`, after 10 cycles containing 3 `irwrite` pulses → `cycle_count`=10, `instr_count`=3.
